matrix_col_streamer: RTL and testbench
======================================

// Module: matrix_col_streamer
// PURPOSE
//   Downstream stage of the 64x10 column-split stage. Captures the four 16x10 column blocks
//   (Matrix_c_0..3) when that stage raises its finish level, then streams them one block per
//   beat over a valid/ready interface to the 1x64 PE array feeder. Elements are 16-bit signed.
// PARAMETERS
//   ELEM_W   16    element width, bits (signed)
//   ROWS     16    rows per block
//   COLS     10    columns per block
//   NBLK     4     blocks per matrix (out_idx width = 2)
//   CHUNK_W  ROWS*COLS*ELEM_W = 2560, block bus width (derived localparam)
// PORTS
//   clk        in   1        clock, all logic on posedge
//   rst        in   1        synchronous, active-high reset
//   in_finish  in   1        upstream finish level; rising edge = new matrix available
//   in_c_0     in   CHUNK_W  block 0 (MSB-most slice of the original 64x10 matrix)
//   in_c_1     in   CHUNK_W  block 1
//   in_c_2     in   CHUNK_W  block 2
//   in_c_3     in   CHUNK_W  block 3
//   out_valid  out  1        out_data/out_idx/out_last valid
//   out_ready  in   1        consumer accepts beat when out_valid & out_ready
//   out_data   out  CHUNK_W  current block
//   out_idx    out  2        index of current block (0..3)
//   out_last   out  1        current beat is final beat of this matrix
//   busy       out  1        capture buffer holds an unsent matrix
//   done       out  1        1-cycle pulse after final beat (or empty matrix) completes
//   overrun    out  1        sticky: rising edge of in_finish seen while busy
// BEHAVIOUR
//   Reset values: out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0, overrun=0;
//     buffers cleared; finish_q=1 so a level held high across reset is not a new edge.
//   Edge detect: edge = in_finish & ~finish_q; finish_q <= in_finish every cycle.
//   FSM IDLE/SEND. IDLE & edge: latch in_c_0..3 into buf[0..3], go SEND, busy=1;
//     out_valid rises the cycle after the edge cycle (latency 1).
//   SEND: out_data=buf[idx], out_idx=idx; all outputs held stable while out_valid & ~out_ready.
//   Handshake (valid&ready): advance to next block to send; on last block -> IDLE,
//     out_valid=0, busy=0, done=1 for one cycle (cycle after final handshake).
//   No bubbles: back-to-back beats when out_ready held 1 (4 beats in 4 cycles).
//   Edge while busy (incl. same cycle as final handshake): not captured, buffer unchanged,
//     overrun<=1 until rst. Edge in IDLE the cycle after done is accepted normally.
//   in_finish falling: no effect. rst mid-stream: everything returns to reset values next
//     cycle; partially sent matrix discarded, no done pulse.
//   out_ready while out_valid=0: ignored.
// CONFIGURATION
//   MCS_ZERO_SKIP_EN defined: at capture, per-block all-zero flags computed; all-zero blocks
//     never emitted; out_idx still reports true block index; out_last marks last non-zero
//     block; all four zero -> no beats, busy stays 0, done pulses cycle after capture.
//   Undefined: all four blocks always emitted in order 0,1,2,3; no zero-detect logic built.
// STRUCTURE
//   Package ddnet_mat_pkg: ELEM_W, ROWS, COLS, NBLK, CHUNK_W, FSM state enum (IDLE, SEND).
//   One sub-module: blk_zero_det (CHUNK_W-wide NOR reduction, registered flag), instanced x4
//     only under MCS_ZERO_SKIP_EN. Edge detect, FSM, buffer mux inline.
// TESTING
//   1. blocks = 16'h0001..0004 replicated, out_ready=1, in_finish 0->1 -> valid next cycle,
//      idx 0,1,2,3 on 4 consecutive cycles, last only on idx 3, done 1 cycle later.
//   2. out_ready toggles 1,0,0,1,... -> data/idx stable during stalls, no beat lost/repeated.
//   3. second in_finish edge (drop then raise) during idx 1 -> overrun=1, stream continues
//      with original data; rst clears overrun.
//   4. rst asserted at idx 2 -> out_valid=0 next cycle, no done; in_finish held high across
//      reset produces no capture.
//   5. MCS_ZERO_SKIP_EN, blocks 1 and 3 all-zero -> beats idx 0,2; last on idx 2; all-zero
//      matrix -> zero beats, done pulse only.
//   6. Signed check: block 0 = all 16'h8000 -> out_data bit-exact, no sign alteration.

Source files
------------

// File: rtl/ddnet_mat_pkg.sv
// Shared sizes, FSM state type and block-selection helper for the column-block streamer.
package ddnet_mat_pkg;

    localparam int ELEM_W  = 16;
    localparam int ROWS    = 16;
    localparam int COLS    = 10;
    localparam int NBLK    = 4;
    localparam int IDX_W   = 2;
    localparam int CHUNK_W = ROWS * COLS * ELEM_W;

    typedef enum logic {IDLE, SEND} state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Lowest set bit of mask at position >= start; found=0 when none remain.
    function automatic pick_t next_set(input logic [NBLK-1:0] mask, input int start);
        pick_t r;
        r = '0;
        for (int i = NBLK - 1; i >= 0; i--) begin
            if (mask[i] && (i >= start)) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/blk_zero_det.sv
// All-zero detector for one block: combinational flag plus a copy registered on capture.
// Latency: zero is same-cycle, zero_flag updates the cycle after en; no flow control.
module blk_zero_det
    import ddnet_mat_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [CHUNK_W-1:0] chunk,
    output logic               zero,
    output logic               zero_flag
);

    assign zero = ~|chunk;

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_flag <= 1'b0;
        end else if (en) begin
            zero_flag <= zero;
        end
    end

endmodule

// File: rtl/matrix_col_streamer.sv
// Captures four column blocks on a rising in_finish and streams one block per beat; valid one
// cycle after the edge, outputs held while stalled. MCS_ZERO_SKIP_EN drops all-zero blocks.
module matrix_col_streamer
    import ddnet_mat_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_finish,
    input  logic [CHUNK_W-1:0] in_c_0,
    input  logic [CHUNK_W-1:0] in_c_1,
    input  logic [CHUNK_W-1:0] in_c_2,
    input  logic [CHUNK_W-1:0] in_c_3,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CHUNK_W-1:0] out_data,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic               overrun
);

    state_t             state;
    logic               finish_q;
    logic               fin_rise;
    logic               capture;
    logic [CHUNK_W-1:0] in_c    [NBLK];
    logic [CHUNK_W-1:0] blk_buf [NBLK];
    logic [NBLK-1:0]    zero_now;
    logic [NBLK-1:0]    zero_q;
    logic [NBLK-1:0]    mask_now;
    logic [NBLK-1:0]    mask_q;
    pick_t              first_pk;
    pick_t              after_first;
    pick_t              nxt_pk;
    pick_t              after_nxt;

    assign in_c[0] = in_c_0;
    assign in_c[1] = in_c_1;
    assign in_c[2] = in_c_2;
    assign in_c[3] = in_c_3;

    assign fin_rise = in_finish & ~finish_q;
    assign capture  = (state == IDLE) & fin_rise;

`ifdef MCS_ZERO_SKIP_EN
    for (genvar g = 0; g < NBLK; g++) begin : g_zdet
        blk_zero_det u_zdet (
            .clk       (clk),
            .rst       (rst),
            .en        (capture),
            .chunk     (in_c[g]),
            .zero      (zero_now[g]),
            .zero_flag (zero_q[g])
        );
    end
`else
    assign zero_now = '0;
    assign zero_q   = '0;
`endif

    assign mask_now = ~zero_now;
    assign mask_q   = ~zero_q;

    // First/next block to emit, and whether anything follows it (drives out_last).
    assign first_pk    = next_set(mask_now, 0);
    assign after_first = next_set(mask_now, int'(first_pk.idx) + 1);
    assign nxt_pk      = next_set(mask_q, int'(out_idx) + 1);
    assign after_nxt   = next_set(mask_q, int'(nxt_pk.idx) + 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            finish_q  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < NBLK; i++) begin
                blk_buf[i] <= '0;
            end
        end else begin
            finish_q <= in_finish;
            done     <= 1'b0;
            if (fin_rise && (state == SEND)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (fin_rise) begin
                        for (int i = 0; i < NBLK; i++) begin
                            blk_buf[i] <= in_c[i];
                        end
                        if (first_pk.found) begin
                            state     <= SEND;
                            busy      <= 1'b1;
                            out_valid <= 1'b1;
                            out_idx   <= first_pk.idx;
                            out_data  <= in_c[first_pk.idx];
                            out_last  <= ~after_first.found;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (nxt_pk.found) begin
                            out_idx  <= nxt_pk.idx;
                            out_data <= blk_buf[nxt_pk.idx];
                            out_last <= ~after_nxt.found;
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_col_streamer.sv
// Directed bench for matrix_col_streamer; expected beats derived from per-matrix emit masks.
module tb_matrix_col_streamer;
    import ddnet_mat_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_finish;
    logic [CHUNK_W-1:0] in_c_0, in_c_1, in_c_2, in_c_3;
    logic               out_valid;
    logic               out_ready;
    logic [CHUNK_W-1:0] out_data;
    logic [IDX_W-1:0]   out_idx;
    logic               out_last;
    logic               busy;
    logic               done;
    logic               overrun;

    int checks   = 0;
    int failures = 0;

    matrix_col_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .in_finish (in_finish),
        .in_c_0    (in_c_0),
        .in_c_1    (in_c_1),
        .in_c_2    (in_c_2),
        .in_c_3    (in_c_3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CHUNK_W-1:0] rep(input logic [15:0] v);
        return {(ROWS * COLS){v}};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Present a new matrix, then follow the stream with ready pattern rpat; emit lists the
    // blocks expected on the output.
    task automatic run_matrix(input logic [15:0] v0, input logic [15:0] v1,
                              input logic [15:0] v2, input logic [15:0] v3,
                              input logic [3:0] emit, input logic [3:0] rpat);
        logic [15:0] vals [4];
        int exp_i;
        int last_i;
        int beats;
        int n_emit;
        int cyc;
        bit seen_done;
        vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
        exp_i = 4; last_i = -1; n_emit = 0;
        for (int i = 3; i >= 0; i--) if (emit[i]) begin exp_i = i; n_emit++; end
        for (int i = 0; i < 4; i++) if (emit[i]) last_i = i;
        in_finish = 1'b0;
        step();
        in_c_0 = rep(v0); in_c_1 = rep(v1); in_c_2 = rep(v2); in_c_3 = rep(v3);
        in_finish = 1'b1;
        check("pre_edge_valid", 32'(out_valid), 32'd0);
        step();
        if (emit == 4'b0000) begin
            check("empty_valid", 32'(out_valid), 32'd0);
            check("empty_busy", 32'(busy), 32'd0);
            check("empty_done", 32'(done), 32'd1);
            step();
            check("empty_done_clr", 32'(done), 32'd0);
            check("empty_valid2", 32'(out_valid), 32'd0);
            return;
        end
        check("lat1_valid", 32'(out_valid), 32'd1);
        beats = 0; cyc = 0; seen_done = 1'b0;
        while (cyc < 40 && !seen_done) begin
            if (out_valid) begin
                check("beat_idx", 32'(out_idx), 32'(exp_i));
                check("beat_data", 32'(out_data === rep(vals[exp_i])), 32'd1);
                check("beat_last", 32'(out_last), 32'(exp_i == last_i));
                check("beat_busy", 32'(busy), 32'd1);
                check("beat_done", 32'(done), 32'd0);
                out_ready = rpat[cyc % 4];
                if (out_ready) begin
                    beats++;
                    exp_i++;
                    while (exp_i < 4 && !emit[exp_i]) exp_i++;
                end
            end else if (done) begin
                seen_done = 1'b1;
                check("done_busy", 32'(busy), 32'd0);
                check("beats", 32'(beats), 32'(n_emit));
                if (rpat == 4'b1111) check("no_bubble", 32'(cyc), 32'(n_emit));
            end else begin
                check("valid_dropped", 32'(out_valid), 32'd1);
            end
            if (!seen_done) begin
                step();
                cyc++;
            end
        end
        check("done_seen", 32'(seen_done), 32'd1);
        step();
        check("done_pulse_1cyc", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_finish = 1'b0; out_ready = 1'b0;
        in_c_0 = '0; in_c_1 = '0; in_c_2 = '0; in_c_3 = '0;
        repeat (2) step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data === '0), 32'd1);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;

        // Back-to-back stream with ready held high.
        out_ready = 1'b1;
        run_matrix(16'h0001, 16'h0002, 16'h0003, 16'h0004, 4'b1111, 4'b1111);

        // Stalls: ready 1,0,0,1 repeating.
        run_matrix(16'h0011, 16'h0012, 16'h0013, 16'h0014, 4'b1111, 4'b1001);

        // Second edge during idx 1 sets overrun; stream continues from the buffer.
        in_c_0 = rep(16'h0021); in_c_1 = rep(16'h0022);
        in_c_2 = rep(16'h0023); in_c_3 = rep(16'h0024);
        in_finish = 1'b0; out_ready = 1'b1;
        step();
        in_finish = 1'b1;
        step();
        check("ov_idx0", 32'(out_idx), 32'd0);
        in_finish = 1'b0;
        step();
        check("ov_idx1", 32'(out_idx), 32'd1);
        check("ov_pre", 32'(overrun), 32'd0);
        in_finish = 1'b1; out_ready = 1'b0;
        in_c_0 = rep(16'hdead); in_c_1 = rep(16'hdead);
        in_c_2 = rep(16'hdead); in_c_3 = rep(16'hdead);
        step();
        check("ov_set", 32'(overrun), 32'd1);
        check("ov_hold_idx", 32'(out_idx), 32'd1);
        check("ov_hold_data", 32'(out_data === rep(16'h0022)), 32'd1);
        out_ready = 1'b1;
        step();
        check("ov_idx2", 32'(out_idx), 32'd2);
        check("ov_data2", 32'(out_data === rep(16'h0023)), 32'd1);
        step();
        check("ov_idx3", 32'(out_idx), 32'd3);
        check("ov_data3", 32'(out_data === rep(16'h0024)), 32'd1);
        check("ov_last3", 32'(out_last), 32'd1);
        step();
        check("ov_done", 32'(done), 32'd1);
        check("ov_sticky", 32'(overrun), 32'd1);
        rst = 1'b1;
        step();
        check("ov_rst_clr", 32'(overrun), 32'd0);
        rst = 1'b0;
        // in_finish stays high across the reset: must not capture.
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_hi_valid", 32'(out_valid), 32'd0);
            check("hold_hi_busy", 32'(busy), 32'd0);
        end

        // Reset in the middle of a stream.
        in_c_0 = rep(16'h0031); in_c_1 = rep(16'h0032);
        in_c_2 = rep(16'h0033); in_c_3 = rep(16'h0034);
        in_finish = 1'b0;
        step();
        in_finish = 1'b1;
        step();
        step();
        step();
        check("mid_idx2", 32'(out_idx), 32'd2);
        rst = 1'b1;
        step();
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_idx", 32'(out_idx), 32'd0);
        check("mid_data", 32'(out_data === '0), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_no_done", 32'(done), 32'd0);
            check("mid_no_valid", 32'(out_valid), 32'd0);
        end

        // Zero blocks: skipped only when the feature is built in.
        out_ready = 1'b1;
`ifdef MCS_ZERO_SKIP_EN
        run_matrix(16'h0005, 16'h0000, 16'h0007, 16'h0000, 4'b0101, 4'b1111);
        run_matrix(16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 4'b1111);
`else
        run_matrix(16'h0005, 16'h0000, 16'h0007, 16'h0000, 4'b1111, 4'b1111);
        run_matrix(16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b1111, 4'b1011);
`endif

        // Negative extremes pass through bit-exact.
        run_matrix(16'h8000, 16'h7fff, 16'hffff, 16'h8001, 4'b1111, 4'b1111);
        check("final_overrun", 32'(overrun), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
